cpu_trace_buffer: RTL

CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

---
 rtl/cpu_trace_pkg.sv | 18 +
 rtl/trace_ram.sv | 32 +++
 rtl/cpu_trace_buffer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared encodings for the CPU trace buffer: capture FSM states and trigger modes.
package cpu_trace_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_POST  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] TM_IMMEDIATE   = 2'd0;
    localparam logic [1:0] TM_PC_MATCH    = 2'd1;
    localparam logic [1:0] TM_INSTR_MATCH = 2'd2;
    localparam logic [1:0] TM_PC_HITS     = 2'd3;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one write port, one read port with a registered output.
module trace_ram #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the array has no reset so it maps onto plain RAM; only the output register is reset.
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    rdata_q <= '0;
        else if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular trace capture of retired instructions with a configurable trigger,
// post-trigger window and oldest-first readout.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter  int PC_W      = 16,
    parameter  int INSTR_W   = 16,
    parameter  int DEPTH     = 16,
    parameter  int POST_TRIG = DEPTH / 2,
    localparam int TRIG_W    = max_w(PC_W, INSTR_W),
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm,
    input  logic [1:0]         trig_mode,
    input  logic [TRIG_W-1:0]  trig_value,
    input  logic [7:0]         trig_hits,
    input  logic               trace_valid,
    input  logic [PC_W-1:0]    trace_pc,
    input  logic [INSTR_W-1:0] trace_instr,
    input  logic               rd_req,
    output logic               rd_valid,
    output logic [PC_W-1:0]    rd_pc,
    output logic [INSTR_W-1:0] rd_instr,
    output logic               rd_last,
    output logic [1:0]         state,
    output logic [CW-1:0]      count
);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] post_cnt_q, post_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [7:0]    hits_q, hits_d;
    logic          rd_valid_q, rd_last_q;

    logic          pc_match, instr_match, trig_hit, sample_en, rd_accept, full;
    logic [7:0]    hits_need;
    logic [AW-1:0] rd_start, rd_addr;

    assign pc_match    = (trace_pc == trig_value[PC_W-1:0]);
    assign instr_match = (trace_instr == trig_value[INSTR_W-1:0]);
    assign hits_need   = (trig_hits == 8'd0) ? 8'd1 : trig_hits;
    assign full        = (count_q == CW'(DEPTH));

    // Arm takes priority over both sample capture and readout in the same cycle.
    assign sample_en = trace_valid && !arm && (state_q == ST_ARMED || state_q == ST_POST);
    assign rd_accept = rd_req && !arm && (state_q == ST_DONE) && (rd_cnt_q != count_q);

    // Once the ring has wrapped, the oldest entry sits at the write pointer.
    assign rd_start = full ? wr_ptr_q : '0;
    assign rd_addr  = rd_start + rd_cnt_q[AW-1:0];

    always_comb begin
        trig_hit = 1'b0;
        case (trig_mode)
            TM_IMMEDIATE:   trig_hit = 1'b1;
            TM_PC_MATCH:    trig_hit = pc_match;
            TM_INSTR_MATCH: trig_hit = instr_match;
            default:        trig_hit = pc_match && ((hits_q + 8'd1) == hits_need);
        endcase
    end

    // NOTE: every next-state signal is given its hold value first so no latches are inferred.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        post_cnt_d = post_cnt_q;
        count_d    = count_q;
        rd_cnt_d   = rd_cnt_q;
        hits_d     = hits_q;

        if (arm) begin
            state_d    = ST_ARMED;
            wr_ptr_d   = '0;
            post_cnt_d = '0;
            count_d    = '0;
            rd_cnt_d   = '0;
            hits_d     = '0;
        end else begin
            if (sample_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (!full) count_d = count_q + CW'(1);
            end
            case (state_q)
                ST_ARMED: begin
                    if (trace_valid) begin
                        if (trig_mode == TM_PC_HITS && pc_match) hits_d = hits_q + 8'd1;
                        if (trig_hit) begin
                            if (POST_TRIG <= 1) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d    = ST_POST;
                                post_cnt_d = AW'(1);
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (trace_valid) begin
                        if (post_cnt_q == AW'(POST_TRIG - 1)) state_d = ST_DONE;
                        else                                  post_cnt_d = post_cnt_q + AW'(1);
                    end
                end
                ST_DONE: begin
                    if (rd_accept) rd_cnt_d = rd_cnt_q + CW'(1);
                    if (rd_last_q) state_d = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            post_cnt_q <= '0;
            count_q    <= '0;
            rd_cnt_q   <= '0;
            hits_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            post_cnt_q <= post_cnt_d;
            count_q    <= count_d;
            rd_cnt_q   <= rd_cnt_d;
            hits_q     <= hits_d;
            rd_valid_q <= rd_accept;
            rd_last_q  <= rd_accept && (rd_cnt_q == count_q - CW'(1));
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W + INSTR_W)
    ) u_trace_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (sample_en),
        .waddr_i (wr_ptr_q),
        .wdata_i ({trace_pc, trace_instr}),
        .re_i    (rd_accept),
        .raddr_i (rd_addr),
        .rdata_o ({rd_pc, rd_instr})
    );

    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign state    = state_q;
    assign count    = count_q;

endmodule
